// File: rtl/drop_door_controller.sv
`default_nettype none
// ============================================================================
// Module   : drop_door_controller
// Brief    : Debounces the baggage-drop request and sequences the trap-door
//            motor through open / hold / close / cooldown with end-stop
//            supervision, a saturating drop counter and a sticky fault.
// Revision : 1.0 - initial release
// ============================================================================
module drop_door_controller #(
    parameter int ARM_CYCLES      = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int MOTION_TIMEOUT  = 64,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             drop_activated,
    input  logic             drop_en,
    input  logic             abort,
    input  logic             open_sw,
    input  logic             closed_sw,
    output logic             motor_open,
    output logic             motor_close,
    output logic [2:0]       door_state,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_OPENING  = 3'd2,
        S_OPEN     = 3'd3,
        S_CLOSING  = 3'd4,
        S_COOLDOWN = 3'd5,
        S_FAULT    = 3'd6,
        S_ILLEGAL  = 3'd7
    } state_t;

    // One shared state timer covers every timed state, so it is sized for the
    // longest of them.
    localparam int c_MAX_A   = (MOTION_TIMEOUT > HOLD_CYCLES) ? MOTION_TIMEOUT : HOLD_CYCLES;
    localparam int c_TMR_MAX = (c_MAX_A > COOLDOWN_CYCLES) ? c_MAX_A : COOLDOWN_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam int c_ARM_W   = $clog2(ARM_CYCLES + 1);

    // Timer value seen on the last cycle of each timed state.
    localparam logic [c_TMR_W-1:0] c_TIMEOUT_LAST = c_TMR_W'(MOTION_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST    = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_COOL_LAST    = c_TMR_W'(COOLDOWN_CYCLES - 1);
    localparam logic [c_ARM_W-1:0] c_ARM_LAST     = c_ARM_W'(ARM_CYCLES - 1);

    state_t               state_q, state_d;
    logic [c_TMR_W-1:0]   tmr_q, tmr_d;
    logic [c_ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 open_s1_q, osw_q;
    logic                 closed_s1_q, csw_q;
    logic                 motor_open_q, motor_close_q, busy_q, fault_q;
    logic [2:0]           door_state_q;

    logic                 w_req;
    logic                 w_both_sw;
    logic                 w_open_entry;

    assign w_req        = drop_activated & drop_en;
    assign w_both_sw    = osw_q & csw_q;
    assign w_open_entry = (state_d == S_OPEN) && (state_q != S_OPEN);

    assign motor_open  = motor_open_q;
    assign motor_close = motor_close_q;
    assign door_state  = door_state_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign drop_count  = cnt_q;

    // Next-state, arm-debounce and state-timer logic.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    arm_cnt_d = c_ARM_W'(1);
                    state_d   = (ARM_CYCLES == 1) ? S_OPENING : S_ARM;
                end
            end
            S_ARM: begin
                if (!w_req || abort) begin
                    arm_cnt_d = '0;
                    state_d   = S_IDLE;
                end else if (arm_cnt_q == c_ARM_LAST) begin
                    arm_cnt_d = '0;
                    state_d   = S_OPENING;
                end else begin
                    arm_cnt_d = arm_cnt_q + c_ARM_W'(1);
                end
            end
            S_OPENING: begin
                // End-stops take priority over the timeout on the same edge.
                if (w_both_sw)                    state_d = S_FAULT;
                else if (abort)                   state_d = S_CLOSING;
                else if (osw_q)                   state_d = S_OPEN;
                else if (tmr_q == c_TIMEOUT_LAST) state_d = S_FAULT;
            end
            S_OPEN: begin
                if (w_both_sw)                           state_d = S_FAULT;
                else if (abort || (tmr_q == c_HOLD_LAST)) state_d = S_CLOSING;
            end
            S_CLOSING: begin
                // Abort is meaningless here: the door is already closing.
                if (w_both_sw)                    state_d = S_FAULT;
                else if (csw_q)                   state_d = S_COOLDOWN;
                else if (tmr_q == c_TIMEOUT_LAST) state_d = S_FAULT;
            end
            S_COOLDOWN: begin
                if (tmr_q == c_COOL_LAST) state_d = S_IDLE;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        if (state_d != state_q) begin
            tmr_d = '0;
        end else if ((state_q == S_OPENING) || (state_q == S_OPEN) ||
                     (state_q == S_CLOSING) || (state_q == S_COOLDOWN)) begin
            tmr_d = tmr_q + c_TMR_W'(1);
        end else begin
            tmr_d = '0;
        end
    end

    // State, counters, end-stop synchronizers and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_s1_q     <= 1'b0;
            osw_q         <= 1'b0;
            closed_s1_q   <= 1'b0;
            csw_q         <= 1'b0;
            state_q       <= S_IDLE;
            tmr_q         <= '0;
            arm_cnt_q     <= '0;
            cnt_q         <= '0;
            motor_open_q  <= 1'b0;
            motor_close_q <= 1'b0;
            door_state_q  <= 3'd0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            open_s1_q     <= open_sw;
            osw_q         <= open_s1_q;
            closed_s1_q   <= closed_sw;
            csw_q         <= closed_s1_q;
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            arm_cnt_q     <= arm_cnt_d;
            if (w_open_entry && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Outputs are decoded from the next state so they line up with state_q.
            motor_open_q  <= (state_d == S_OPENING);
            motor_close_q <= (state_d == S_CLOSING);
            door_state_q  <= state_d;
            busy_q        <= (state_d != S_IDLE);
            fault_q       <= (state_d == S_FAULT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_drop_door_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_drop_door_controller
// Brief    : Self-checking bench for drop_door_controller. A behavioural door
//            reference model and a simple door plant run alongside two DUTs
//            (default counter width and a 2-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_drop_door_controller;

    localparam int ARM  = 4;
    localparam int HOLD = 16;
    localparam int TMO  = 64;
    localparam int COOL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drop_activated = 1'b0;
    logic drop_en = 1'b0;
    logic abort = 1'b0;
    logic plant_auto = 1'b1;
    logic man_open = 1'b0;
    logic man_closed = 1'b1;
    logic p_open = 1'b0;
    logic p_closed = 1'b1;
    wire  open_sw   = plant_auto ? p_open   : man_open;
    wire  closed_sw = plant_auto ? p_closed : man_closed;

    logic       motor_open, motor_close, busy, fault;
    logic [2:0] door_state;
    logic [7:0] drop_count;
    logic       s_motor_open, s_motor_close, s_busy, s_fault;
    logic [2:0] s_door_state;
    logic [1:0] s_drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: state number, cycles spent in it, drop totals.
    int   m_state = 0;
    int   m_age = 0;
    int   m_cnt = 0;
    int   m_cnt2 = 0;
    int   m_nxt;
    int   m_done;
    logic [1:0] m_so = 2'b00;
    logic [1:0] m_sc = 2'b00;
    logic m_o, m_c, m_req;

    // Door plant controls.
    int open_dly = 5;
    int close_dly = 1;
    int pcnt = 0;
    int p_prev = 0;

    logic [14:0] dut_vec, exp_vec;
    logic [8:0]  sat_vec, exp_sat;

    drop_door_controller #(
        .ARM_CYCLES(ARM), .HOLD_CYCLES(HOLD), .MOTION_TIMEOUT(TMO),
        .COOLDOWN_CYCLES(COOL), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drop_activated(drop_activated), .drop_en(drop_en),
        .abort(abort), .open_sw(open_sw), .closed_sw(closed_sw),
        .motor_open(motor_open), .motor_close(motor_close), .door_state(door_state),
        .busy(busy), .fault(fault), .drop_count(drop_count)
    );

    drop_door_controller #(
        .ARM_CYCLES(ARM), .HOLD_CYCLES(HOLD), .MOTION_TIMEOUT(TMO),
        .COOLDOWN_CYCLES(COOL), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .drop_activated(drop_activated), .drop_en(drop_en),
        .abort(abort), .open_sw(open_sw), .closed_sw(closed_sw),
        .motor_open(s_motor_open), .motor_close(s_motor_close), .door_state(s_door_state),
        .busy(s_busy), .fault(s_fault), .drop_count(s_drop_count)
    );

    always #5 clk = ~clk;

    assign dut_vec = {motor_open, motor_close, door_state, busy, fault, drop_count};
    assign sat_vec = {s_motor_open, s_motor_close, s_door_state, s_busy, s_fault, s_drop_count};

    always_comb begin
        exp_vec = {(m_state == 2), (m_state == 4), m_state[2:0], (m_state != 0),
                   (m_state == 6), m_cnt[7:0]};
        exp_sat = {(m_state == 2), (m_state == 4), m_state[2:0], (m_state != 0),
                   (m_state == 6), m_cnt2[1:0]};
    end

    // Behavioural model: states numbered 0..6, rules written from the door's
    // point of view (how many cycles have elapsed, what the end-stops read).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_age = 0; m_cnt = 0; m_cnt2 = 0; m_so = 2'b00; m_sc = 2'b00;
        end else begin
            m_o    = m_so[1];
            m_c    = m_sc[1];
            m_req  = drop_activated && drop_en;
            m_nxt  = m_state;
            m_done = m_age + 1;
            case (m_state)
                0: if (m_req) m_nxt = (ARM == 1) ? 2 : 1;
                1: if (!m_req || abort) m_nxt = 0;
                   else if (m_done + 1 >= ARM) m_nxt = 2;
                2: if (m_o && m_c) m_nxt = 6;
                   else if (abort) m_nxt = 4;
                   else if (m_o) m_nxt = 3;
                   else if (m_done == TMO) m_nxt = 6;
                3: if (m_o && m_c) m_nxt = 6;
                   else if (abort || m_done == HOLD) m_nxt = 4;
                4: if (m_o && m_c) m_nxt = 6;
                   else if (m_c) m_nxt = 5;
                   else if (m_done == TMO) m_nxt = 6;
                5: if (m_done == COOL) m_nxt = 0;
                default: m_nxt = 6;
            endcase
            if (m_nxt == 3 && m_state != 3) begin
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
            end
            m_age   = (m_nxt == m_state) ? m_age + 1 : 0;
            m_state = m_nxt;
            m_so    = {m_so[0], open_sw};
            m_sc    = {m_sc[0], closed_sw};
        end
    end

    // Door plant driven by the model's motor commands: the open end-stop
    // closes open_dly cycles into opening, the closed one close_dly cycles
    // into closing (0 = never).
    always @(negedge clk) begin
        if (!rst_n) begin
            p_open = 1'b0; p_closed = 1'b1; pcnt = 0; p_prev = 0;
        end else begin
            if (m_state != p_prev) pcnt = 0;
            p_prev = m_state;
            if (m_state == 2) begin
                p_closed = 1'b0;
                pcnt = pcnt + 1;
                if (open_dly > 0 && pcnt >= open_dly) p_open = 1'b1;
            end else if (m_state == 4) begin
                p_open = 1'b0;
                pcnt = pcnt + 1;
                if (close_dly > 0 && pcnt >= close_dly) p_closed = 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; abort = 1'b0; drop_activated = 1'b0; drop_en = 1'b0;
        plant_auto = 1'b1; man_open = 1'b0; man_closed = 1'b1;
        open_dly = 5; close_dly = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input int st, input int budget, output bit ok);
        int n = 0;
        while (m_state != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (m_state == st);
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk);
        checks++;
        if (dut_vec !== 15'd0) begin errors++; $display("FAIL reset_state: got %h want 0", dut_vec); end
        checks++;
        if (sat_vec !== 9'd0) begin errors++; $display("FAIL reset_state_sat: got %h want 0", sat_vec); end
        rst_n = 1'b1; open_dly = 0; drop_en = 1'b1; drop_activated = 1'b1;
        wait_state(2, 20, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || motor_open !== 1'b1) begin errors++; $display("FAIL reset_pre_opening: motor_open=%b want 1", motor_open); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({motor_open, motor_close, s_motor_open} !== 3'b000) begin
            errors++; $display("FAIL reset_async_motor: motors=%b want 000", {motor_open, motor_close, s_motor_open});
        end
        @(negedge clk);
        drop_activated = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== 15'd0 || sat_vec !== 9'd0) begin
            errors++; $display("FAIL reset_release: got %h/%h want 0/0", dut_vec, sat_vec);
        end
    endtask

    task automatic test_nominal();
        int len[8];
        int cyc = 0;
        bit saw_cool = 0;
        bit done = 0;
        for (int i = 0; i < 8; i++) len[i] = 0;
        do_reset();
        open_dly = 5; close_dly = 1; drop_en = 1'b1; drop_activated = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL nominal_model cyc %0d: got %h want %h", cyc, dut_vec, exp_vec); end
            if (cyc == 3) begin
                checks++;
                if (door_state !== 3'd1) begin errors++; $display("FAIL nominal_arm: state=%0d want 1", door_state); end
            end
            if (cyc == 4) begin
                checks++;
                if (door_state !== 3'd2) begin errors++; $display("FAIL nominal_opening: state=%0d want 2", door_state); end
                drop_activated = 1'b0;
            end
            len[door_state]++;
            if (door_state == 3'd5) saw_cool = 1;
            if (saw_cool && door_state == 3'd0) done = 1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL nominal_timeout: state=%0d want 0", door_state); end
        checks++;
        if (len[2] != 7) begin errors++; $display("FAIL nominal_opening_len: got %0d want 7", len[2]); end
        checks++;
        if (len[3] != HOLD) begin errors++; $display("FAIL nominal_open_len: got %0d want %0d", len[3], HOLD); end
        checks++;
        if (len[4] != 3) begin errors++; $display("FAIL nominal_closing_len: got %0d want 3", len[4]); end
        checks++;
        if (len[5] != COOL) begin errors++; $display("FAIL nominal_cool_len: got %0d want %0d", len[5], COOL); end
        checks++;
        if (drop_count !== 8'd1) begin errors++; $display("FAIL nominal_count: got %0d want 1", drop_count); end
    endtask

    task automatic test_debounce();
        bit ok;
        do_reset();
        drop_en = 1'b1; drop_activated = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 3) drop_activated = 1'b0;
            checks++;
            if ({motor_open, motor_close} !== 2'b00) begin errors++; $display("FAIL debounce_motor cyc %0d: got %b want 00", i, {motor_open, motor_close}); end
        end
        checks++;
        if (door_state !== 3'd0) begin errors++; $display("FAIL debounce_first_burst: state=%0d want 0", door_state); end
        drop_activated = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (door_state !== 3'd2) begin errors++; $display("FAIL debounce_second_burst: state=%0d want 2", door_state); end
        drop_activated = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_state(0, 200, ok);
        drop_en = 1'b0; drop_activated = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (!ok || door_state !== 3'd0 || busy !== 1'b0) begin
                errors++; $display("FAIL debounce_disabled cyc %0d: state=%0d busy=%b want 0/0", i, door_state, busy);
            end
        end
        drop_activated = 1'b0;
    endtask

    task automatic test_abort();
        bit ok;
        do_reset();
        drop_en = 1'b1; drop_activated = 1'b1;
        @(negedge clk);
        checks++;
        if (door_state !== 3'd1) begin errors++; $display("FAIL abort_arm_entry: state=%0d want 1", door_state); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; drop_activated = 1'b0;
        checks++;
        if (door_state !== 3'd0) begin errors++; $display("FAIL abort_arm: state=%0d want 0", door_state); end
        // Abort on the tenth cycle of OPENING.
        open_dly = 0; drop_activated = 1'b1;
        wait_state(2, 20, ok);
        drop_activated = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (!ok || door_state !== 3'd4 || drop_count !== 8'd0) begin
            errors++; $display("FAIL abort_opening: state=%0d count=%0d want 4/0", door_state, drop_count);
        end
        wait_state(0, 200, ok);
        open_dly = 3; drop_activated = 1'b1;
        wait_state(3, 40, ok);
        drop_activated = 1'b0;
        checks++;
        if (!ok || drop_count !== 8'd1) begin errors++; $display("FAIL abort_open_count: count=%0d want 1", drop_count); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (door_state !== 3'd4 || drop_count !== 8'd1) begin
            errors++; $display("FAIL abort_open: state=%0d count=%0d want 4/1", door_state, drop_count);
        end
        wait_state(0, 200, ok);
    endtask

    task automatic test_fault_timeout();
        bit ok;
        do_reset();
        open_dly = 0; drop_en = 1'b1; drop_activated = 1'b1;
        wait_state(2, 20, ok);
        drop_activated = 1'b0;
        repeat (63) @(negedge clk);
        checks++;
        if (!ok || door_state !== 3'd2) begin errors++; $display("FAIL timeout_early: state=%0d want 2", door_state); end
        @(negedge clk);
        checks++;
        if ({door_state, fault, motor_open, motor_close} !== 6'b110100) begin
            errors++; $display("FAIL timeout_fault: st/f/mo/mc=%b want 110100", {door_state, fault, motor_open, motor_close});
        end
        for (int i = 0; i < 20; i++) begin
            drop_activated = i[0];
            abort = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++;
            if ({door_state, fault, motor_open, motor_close} !== 6'b110100) begin
                errors++; $display("FAIL fault_sticky cyc %0d: got %b want 110100", i, {door_state, fault, motor_open, motor_close});
            end
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (fault !== 1'b0 || door_state !== 3'd0) begin errors++; $display("FAIL fault_cleared: fault=%b state=%0d want 0/0", fault, door_state); end
    endtask

    task automatic test_fault_both();
        bit ok;
        int n = 0;
        do_reset();
        open_dly = 3; close_dly = 0; drop_en = 1'b1; drop_activated = 1'b1;
        wait_state(3, 40, ok);
        drop_activated = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (!ok || door_state !== 3'd4) begin errors++; $display("FAIL both_closing_entry: state=%0d want 4", door_state); end
        man_open = 1'b1; man_closed = 1'b1; plant_auto = 1'b0;
        while (m_state != 6 && n < 8) begin @(negedge clk); n++; end
        checks++;
        if (m_state != 6 || door_state !== 3'd6 || fault !== 1'b1 || drop_count !== 8'd1) begin
            errors++; $display("FAIL both_fault: state=%0d fault=%b count=%0d want 6/1/1", door_state, fault, drop_count);
        end
    endtask

    task automatic test_saturation();
        int sat_exp[5] = '{1, 2, 3, 3, 3};
        bit ok1, ok2, ok3;
        do_reset();
        open_dly = 2; close_dly = 1; drop_en = 1'b1;
        for (int d = 0; d < 5; d++) begin
            drop_activated = 1'b1;
            wait_state(2, 20, ok1);
            drop_activated = 1'b0;
            wait_state(5, 200, ok2);
            wait_state(0, 50, ok3);
            checks++;
            if (!(ok1 && ok2 && ok3) || s_drop_count !== sat_exp[d][1:0] || drop_count !== 8'(d + 1)) begin
                errors++; $display("FAIL saturation drop %0d: count2=%0d count8=%0d want %0d/%0d",
                                   d + 1, s_drop_count, drop_count, sat_exp[d], d + 1);
            end
        end
    endtask

    task automatic test_random();
        int fcnt = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin errors++; $display("FAIL random_main cyc %0d: got %h want %h", i, dut_vec, exp_vec); end
            checks++;
            if (sat_vec !== exp_sat) begin errors++; $display("FAIL random_sat cyc %0d: got %h want %h", i, sat_vec, exp_sat); end
            if (m_state == 6) fcnt++; else fcnt = 0;
            if (!rst_n) rst_n = 1'b1;
            else if (fcnt > 5 || $urandom_range(0, 1499) == 0) begin rst_n = 1'b0; fcnt = 0; end
            if (m_state == 0) begin
                open_dly  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 9));
                close_dly = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
            end
            drop_en        = ($urandom_range(0, 7) != 0);
            drop_activated = ($urandom_range(0, 3) != 0);
            abort          = ($urandom_range(0, 49) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_debounce();
        test_abort();
        test_fault_timeout();
        test_fault_both();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/drop_door_controller.md
Name: drop_door_controller

Overview:
- Sequential stage directly downstream of the baggage-drop decision logic. Consumes the combinational drop_activated request together with drop_en.
- Debounces the request and drives the trap-door motor through a timed open/hold/close cycle with end-stop supervision.
- Counts completed drops and latches a fault on motor timeout or inconsistent end-stops.

Parameters:
ARM_CYCLES, 4, consecutive cycles request must be high before door motion starts (>=1)
HOLD_CYCLES, 16, cycles door is held open once open end-stop seen (>=1)
MOTION_TIMEOUT, 64, max cycles allowed in OPENING or CLOSING before fault (>=1)
COOLDOWN_CYCLES, 8, dead time after door closes before re-arming (>=1)
CNT_W, 8, width of drop counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
drop_activated  input  1  drop request from decision stage (synchronous to clk)
drop_en  input  1  global drop enable (synchronous to clk)
abort  input  1  operator abort (synchronous to clk)
open_sw  input  1  door-fully-open end-stop (asynchronous)
closed_sw  input  1  door-fully-closed end-stop (asynchronous)
motor_open  output  1  drive door open
motor_close  output  1  drive door closed
door_state  output  3  current FSM state encoding
busy  output  1  high whenever state != IDLE
fault  output  1  sticky fault indicator
drop_count  output  CNT_W  completed-open count, saturating

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async assert, sync release):
  - state=IDLE; all counters 0; synchronizers cleared.
  - Every output is 0: motor_open, motor_close, door_state, busy, fault, drop_count.
  - Motors drop immediately on reset assertion, including mid-motion.
- Synchronization: open_sw and closed_sw each pass through a 2-flop synchronizer (2-cycle latency). FSM uses only the synced versions (osw, csw).
- Outputs: all registered and Moore-decoded from state.
  - motor_open=1 only in OPENING; motor_close=1 only in CLOSING. Never both high.
  - door_state = state encoding.
- req = drop_activated & drop_en.
- States and encodings:
  - IDLE(0): req -> ARM, arm_cnt=1. ARM_CYCLES=1 -> directly to OPENING.
  - ARM(1):
    - !req or abort -> IDLE, arm_cnt=0.
    - Otherwise arm_cnt++. When req has been sampled high on ARM_CYCLES consecutive edges -> OPENING.
    - Default: req high on edges 1..4 gives OPENING after edge 4.
  - OPENING(2): tmr++ each cycle.
    - Priority: osw&csw -> FAULT; abort -> CLOSING (tmr=0); osw -> OPEN (tmr=0); tmr==MOTION_TIMEOUT-1 -> FAULT.
  - OPEN(3):
    - On entry, drop_count++, saturating at all-ones.
    - abort -> CLOSING.
    - After HOLD_CYCLES cycles in OPEN -> CLOSING.
    - osw&csw -> FAULT.
  - CLOSING(4): tmr++.
    - Priority: osw&csw -> FAULT; csw -> COOLDOWN (tmr=0); tmr==MOTION_TIMEOUT-1 -> FAULT.
    - abort ignored.
  - COOLDOWN(5): after COOLDOWN_CYCLES cycles -> IDLE. req and abort ignored. A held request re-arms from scratch in IDLE.
  - FAULT(6): fault=1, motors 0. Exit only via rst_n.
  - Encoding 7 is illegal and recovers to FAULT.
- Timing rules:
  - Timers count from 0 on state entry.
  - A timeout fires on the MOTION_TIMEOUT-th cycle spent in the state.
  - End-stop and timeout on the same edge: the end-stop wins.
- drop_count holds its value through FAULT and clears only on reset.

Test Plan:
- Reset values: assert rst_n=0 mid-OPENING -> motor_open drops to 0 immediately. After release: door_state=0, busy=0, fault=0, drop_count=0.
- Nominal drop (defaults): req high 4 edges; raise open_sw 5 cycles after OPENING entry; raise closed_sw when motor_close rises.
  - OPENING after edge 4; OPEN 2 cycles after open_sw; drop_count=1.
  - OPEN lasts 16 cycles, then CLOSING.
  - COOLDOWN 8 cycles, then IDLE.
- Debounce: req high 3 cycles, low 1, high 4 -> first burst returns to IDLE, no motor activity; second burst reaches OPENING. drop_enable=0 with drop_activated=1 -> stays IDLE.
- Abort: abort during ARM -> IDLE. Abort in OPENING at cycle 10 -> CLOSING next edge, drop_count unchanged. Abort in OPEN -> CLOSING, count already incremented.
- Faults:
  - open_sw never rises -> FAULT after 64 cycles in OPENING, motors 0, fault=1; stays FAULT with req toggling until reset.
  - open_sw and closed_sw both high in CLOSING -> FAULT.
- Saturation: CNT_W=2, run 5 complete drops -> drop_count reads 1,2,3,3,3.
